// File: rtl/mac_operand_accumulator.sv
// ---------------------------------------------------------------------------
// mac_operand_accumulator
//
// Purpose:
//   Upstream and feedback stage for the 8x8 Dadda MAC processing block.
//   Operand pairs arrive on a valid/ready handshake. Each accepted pair is
//   turned into a registered 64-bit partial-product array for the reduction
//   tree. The block holds the 16-bit accumulator that feeds the tree's M
//   input. It captures the 17-bit sum that comes back and saturates it to
//   16 bits. After N_TERMS products the dot-product result is offered on a
//   valid/ready output handshake.
//
// Ports:
//   clk        single clock, rising-edge
//   rst        synchronous, active-high reset (overrides everything)
//   in_valid   operand pair present
//   in_ready   block accepts a pair this cycle (combinational)
//   a, b       8-bit unsigned operands
//   clear      synchronous abort of the current dot product
//   pp_out     registered partial products, bit 8*i+j = a[i] & b[j]
//   acc_out    accumulator register, drives the tree's M input
//   mac_in     17-bit sum returned by the tree (acc_out + product)
//   out_valid  result available
//   out_ready  consumer takes the result
//   result     final accumulator value, meaningful while out_valid=1
//   overflow   sticky saturation flag for the current dot product
// ---------------------------------------------------------------------------
module mac_operand_accumulator #(
  parameter int N_TERMS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        clear,
  output logic [63:0] pp_out,
  output logic [15:0] acc_out,
  input  logic [16:0] mac_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        overflow
);

  // IDLE: no term issued yet. ACCUM: at least one term issued.
  // DONE: the finished result is being held for the consumer.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // The counters are 8 bits wide, so the term count and the index of the
  // last term are cast once to that width.
  localparam logic [7:0] n_terms_c  = 8'(N_TERMS);
  localparam logic [7:0] last_idx_c = 8'(N_TERMS - 1);

  logic [1:0]  state;
  logic [7:0]  issued_cnt;
  logic [7:0]  acc_cnt;
  logic        pp_vld;
  logic [15:0] acc;
  logic        ovf;
  logic [63:0] pp_next;
  logic        accept;
  logic        release_result;

  // The AND array is plain wiring. Bit 8*i+j carries a[i] & b[j], which is
  // the P[i][j] input of the reduction tree.
  for (genvar i = 0; i < 8; i++) begin : g_row
    for (genvar j = 0; j < 8; j++) begin : g_col
      assign pp_next[8*i+j] = a[i] & b[j];
    end
  end

  // A pair is taken only when there is room for another term in the
  // current dot product. clear and rst block acceptance in the same cycle,
  // so an abort never races with a new operand.
  always_comb begin
    in_ready       = (state != DONE) && (issued_cnt < n_terms_c) && !clear && !rst;
    accept         = in_valid && in_ready;
    release_result = (state == DONE) && out_ready;
  end

  // The partial-product register is loaded only on an accept. On every
  // other edge it drops to zero, so the tree then returns mac_in equal to
  // acc_out. pp_vld marks which edge's mac_in carries a real product. An
  // accept is impossible while clear or rst is high, so those cases also
  // zero the register and discard the in-flight product.
  always_ff @(posedge clk) begin
    if (rst) begin
      pp_out <= '0;
      pp_vld <= 1'b0;
    end else if (accept) begin
      pp_out <= pp_next;
      pp_vld <= 1'b1;
    end else begin
      pp_out <= '0;
      pp_vld <= 1'b0;
    end
  end

  // This is the control and accumulator path. clear and the output
  // handshake both return to a clean IDLE with a zero accumulator.
  // Otherwise accept and accumulate are independent and may happen on the
  // same edge, which gives one pair per clock. A sum that spills into bit
  // 16 pins the accumulator at all-ones and sets the sticky flag. Later
  // terms keep it pinned, because the tree then returns at least 16'hFFFF.
  // The last accumulate can never coincide with an accept, because every
  // term has already been issued by then.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      issued_cnt <= '0;
      acc_cnt    <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
    end else if (clear || release_result) begin
      state      <= IDLE;
      issued_cnt <= '0;
      acc_cnt    <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
    end else begin
      if (accept) begin
        issued_cnt <= issued_cnt + 8'd1;
        if (state == IDLE) begin
          state <= ACCUM;
        end
      end
      if (pp_vld) begin
        if (mac_in[16]) begin
          acc <= 16'hFFFF;
          ovf <= 1'b1;
        end else begin
          acc <= mac_in[15:0];
        end
        acc_cnt <= acc_cnt + 8'd1;
        if (acc_cnt == last_idx_c) begin
          state <= DONE;
        end
      end
    end
  end

  // The accumulator is frozen in DONE, so result and overflow stay stable
  // for as long as the consumer applies backpressure.
  always_comb begin
    acc_out   = acc;
    out_valid = (state == DONE);
    result    = acc;
    overflow  = ovf;
  end

endmodule

// File: tb/tb_mac_operand_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac_operand_accumulator
//
// Purpose:
//   Self-checking bench for mac_operand_accumulator with N_TERMS=4. The
//   processing block is modelled behaviourally: mac_in equals acc_out plus
//   the weighted sum of pp_out. Expected dot-product results come from a
//   saturating reference model. They are pushed to a queue when a run
//   finishes and popped when the DUT raises out_valid.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mac_operand_accumulator;

  localparam int NT = 4;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        clear = 1'b0;
  logic [63:0] pp_out;
  logic [15:0] acc_out;
  logic [16:0] mac_in;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t exp_v;
  bit   ok;

  logic [15:0] m_acc;
  logic        m_ovf;

  mac_operand_accumulator #(.N_TERMS(NT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .clear(clear), .pp_out(pp_out), .acc_out(acc_out),
    .mac_in(mac_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Behavioural processing block: weighted partial-product sum plus M.
  always_comb begin
    logic [16:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        prod = prod + (17'(pp_out[8*i+j]) << (i + j));
      end
    end
    mac_in = {1'b0, acc_out} + prod;
  end

  // Reference AND array, built without the DUT's indexing scheme.
  function automatic logic [63:0] pp_model(input logic [7:0] x, input logic [7:0] y);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) r[8*i +: 8] = y;
    end
    return r;
  endfunction

  // Saturating reference accumulator.
  task automatic model_reset();
    m_acc = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_add(input logic [7:0] x, input logic [7:0] y);
    logic [16:0] s;
    s = {1'b0, m_acc} + 17'(16'(x) * 16'(y));
    if (s[16]) begin
      m_acc = 16'hFFFF;
      m_ovf = 1'b1;
    end else begin
      m_acc = s[15:0];
    end
  endtask

  task automatic model_push();
    sb.push_back('{res: m_acc, ovf: m_ovf});
    model_reset();
  endtask

  // Called at #1 after a rising edge. It returns at #1 after the edge that
  // accepted the pair.
  task automatic send_pair(input logic [7:0] x, input logic [7:0] y);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    a = x;
    b = y;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_pair timeout a=%0d b=%0d", x, y);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (got) model_add(x, y);
  endtask

  // Waits at falling edges for out_valid, with a cycle budget.
  task automatic wait_out_valid(output bit found);
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pp_out, acc_out, out_valid, result, overflow, in_ready} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state pp=%h acc=%h ov=%b res=%h of=%b rdy=%b required all zero",
               pp_out, acc_out, out_valid, result, overflow, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready got %b required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_pair(3, 5);
    send_pair(2, 7);
    send_pair(10, 10);
    send_pair(1, 1);
    model_push();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_early_valid got %b required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_latency out_valid got %b required 1", out_valid);
    end
    exp_v = sb.pop_front();
    checks++;
    if (result !== exp_v.res || overflow !== exp_v.ovf) begin
      errors++;
      $display("[TB] FAIL basic_result got %0d/%b required %0d/%b", result, overflow, exp_v.res, exp_v.ovf);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_after_hs out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    send_pair(255, 255);
    send_pair(255, 255);
    checks++;
    if (acc_out !== 16'd65025) begin
      errors++;
      $display("[TB] FAIL sat_first_term got %0d required 65025", acc_out);
    end
    send_pair(255, 255);
    checks++;
    if (acc_out !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL sat_second_term got %h required ffff", acc_out);
    end
    send_pair(255, 255);
    model_push();
    wait_out_valid(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL sat_valid timeout out_valid=%b required 1", out_valid);
    end else begin
      exp_v = sb.pop_front();
      if (result !== exp_v.res || overflow !== exp_v.ovf) begin
        errors++;
        $display("[TB] FAIL sat_result got %h/%b required %h/%b", result, overflow, exp_v.res, exp_v.ovf);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NT; k++) send_pair(1, 1);
    model_push();
    wait_out_valid(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL sat_followup timeout out_valid=%b required 1", out_valid);
    end else begin
      exp_v = sb.pop_front();
      if (result !== exp_v.res || overflow !== exp_v.ovf) begin
        errors++;
        $display("[TB] FAIL sat_followup got %0d/%b required %0d/%b", result, overflow, exp_v.res, exp_v.ovf);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_pair(3, 5);
    send_pair(2, 7);
    send_pair(10, 10);
    send_pair(1, 1);
    model_push();
    wait_out_valid(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL bp_valid timeout out_valid=%b required 1", out_valid);
    end else begin
      exp_v = sb.pop_front();
      for (int n = 0; n < 5; n++) begin
        checks++;
        if (out_valid !== 1'b1 || result !== exp_v.res || overflow !== exp_v.ovf ||
            in_ready !== 1'b0 || pp_out !== '0) begin
          errors++;
          $display("[TB] FAIL bp_hold cyc=%0d ov=%b res=%0d of=%b rdy=%b pp=%h required 1/%0d/%b/0/0",
                   n, out_valid, result, overflow, in_ready, pp_out, exp_v.res, exp_v.ovf);
        end
        in_valid = n[0];
        a = 8'd9;
        b = 8'd9;
        @(posedge clk);
        #1;
        @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== exp_v.res || pp_out !== '0) begin
        errors++;
        $display("[TB] FAIL bp_final_hold ov=%b res=%0d pp=%h required 1/%0d/0", out_valid, result, pp_out, exp_v.res);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc_out !== 16'd0) begin
      errors++;
      $display("[TB] FAIL bp_release ov=%b rdy=%b acc=%0d required 0/1/0", out_valid, in_ready, acc_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_gapped();
    logic [7:0] xs [4];
    logic [7:0] ys [4];
    int         gaps [4];
    xs = '{8'd4, 8'd0, 8'd8, 8'd15};
    ys = '{8'd4, 8'd9, 8'd2, 8'd15};
    gaps = '{1, 3, 2, 0};
    out_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      send_pair(xs[p], ys[p]);
      @(negedge clk);
      checks++;
      if (pp_out !== pp_model(xs[p], ys[p])) begin
        errors++;
        $display("[TB] FAIL gap_pp pair=%0d got %h required %h", p, pp_out, pp_model(xs[p], ys[p]));
      end
      for (int g = 0; g < gaps[p]; g++) begin
        @(negedge clk);
        checks++;
        if (pp_out !== '0) begin
          errors++;
          $display("[TB] FAIL gap_idle_pp pair=%0d got %h required 0", p, pp_out);
        end
      end
      if (p < 3) begin
        @(posedge clk);
        #1;
      end
    end
    model_push();
    wait_out_valid(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL gap_result timeout out_valid=%b required 1", out_valid);
    end else begin
      exp_v = sb.pop_front();
      if (result !== exp_v.res || overflow !== exp_v.ovf) begin
        errors++;
        $display("[TB] FAIL gap_result got %0d/%b required %0d/%b", result, overflow, exp_v.res, exp_v.ovf);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    send_pair(3, 5);
    send_pair(2, 7);
    model_reset();
    clear = 1'b1;
    in_valid = 1'b1;
    a = 8'd9;
    b = 8'd9;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || acc_out !== 16'd15) begin
      errors++;
      $display("[TB] FAIL clear_pre rdy=%b acc=%0d required 0/15", in_ready, acc_out);
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (acc_out !== '0 || pp_out !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_post acc=%0d pp=%h ov=%b rdy=%b required 0/0/0/1", acc_out, pp_out, out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NT; k++) send_pair(1, 2);
    model_push();
    wait_out_valid(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL clear_rerun timeout out_valid=%b required 1", out_valid);
    end else begin
      exp_v = sb.pop_front();
      if (result !== exp_v.res || overflow !== exp_v.ovf) begin
        errors++;
        $display("[TB] FAIL clear_rerun got %0d/%b required %0d/%b", result, overflow, exp_v.res, exp_v.ovf);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b1;
    send_pair(5, 5);
    send_pair(6, 6);
    model_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    a = 8'd7;
    b = 8'd7;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({pp_out, acc_out, out_valid, result, overflow} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_mid pp=%h acc=%0d ov=%b res=%0d of=%b rdy=%b required zeros, rdy 1",
               pp_out, acc_out, out_valid, result, overflow, in_ready);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NT; k++) send_pair(2, 3);
    model_push();
    wait_out_valid(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL rst_rerun timeout out_valid=%b required 1", out_valid);
    end else begin
      exp_v = sb.pop_front();
      if (result !== exp_v.res || overflow !== exp_v.ovf) begin
        errors++;
        $display("[TB] FAIL rst_rerun got %0d/%b required %0d/%b", result, overflow, exp_v.res, exp_v.ovf);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Scenarios run in sequence. Each one leaves the DUT idle, #1 after a
  // rising edge.
  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_saturate();
    test_backpressure();
    test_gapped();
    test_clear();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
